// File: rtl/conv_line_tap_reader_pkg.sv
// Shared constants, state encoding and width helper for the convolution line-tap reader.
package conv_pkg;

  localparam int unsigned KERNEL_K = 5;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned LINE_W   = 32;

  typedef enum logic {StFill, StStream} state_e;

  // Ceiling log2, never below 1 so it is always usable as a vector width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/conv_line_tap_reader_if.sv
// Pixel-stream input and vertical-column output bundle of the line-tap reader.
interface conv_line_tap_reader_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 32,
  parameter int unsigned K = 5
);
  import conv_pkg::*;

  localparam int unsigned AW = clog2(W);

  logic           i_valid;
  logic           i_sof;
  logic [N-1:0]   i_data;
  logic           o_valid;
  logic [K*N-1:0] o_taps;
  logic [AW-1:0]  o_col;
  logic           o_eol;
  logic           o_filling;

  modport master (
    output i_valid, i_sof, i_data,
    input  o_valid, o_taps, o_col, o_eol, o_filling
  );

  modport slave (
    input  i_valid, i_sof, i_data,
    output o_valid, o_taps, o_col, o_eol, o_filling
  );

endinterface

// File: rtl/conv_line_tap_reader_line_store_ram.sv
// W x N line store: combinational read of the old word, write at the clock edge,
// so a read and write to the same address in one cycle returns the old contents.
module line_store_ram #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [N-1:0]  wdata_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_line_tap_reader.sv
// Keeps the last K-1 lines in a shifting chain of line stores and emits, per accepted
// pixel, the K vertically aligned pixels of its column once K-1 full lines are buffered.
module conv_line_tap_reader
  import conv_pkg::*;
#(
  parameter int unsigned N = PIX_W,
  parameter int unsigned W = LINE_W,
  parameter int unsigned K = KERNEL_K
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  conv_line_tap_reader_if.slave  bus
);

  localparam int unsigned AW = clog2(W);
  localparam int unsigned RW = clog2(K);
  localparam logic [AW-1:0] ColLast = AW'(W - 1);
  localparam logic [RW-1:0] RowSat  = RW'(K - 1);
  localparam logic [RW-1:0] RowFull = RW'(K - 2);

  state_e         state_q, state_d;
  logic [AW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [AW-1:0]  addr;
  logic [N-1:0]   rd [K-1];
  logic [K*N-1:0] taps_d;
  logic [K*N-1:0] taps_q;
  logic [AW-1:0]  ocol_q;
  logic           valid_q, eol_q;
  logic           filling;

  // A start-of-frame pixel always lands in column 0 regardless of the counter.
  assign addr = bus.i_sof ? '0 : col_q;

  for (genvar j = 0; j < K - 1; j++) begin : g_store
    logic [N-1:0] wdata;
    if (j == 0) begin : g_head
      assign wdata = bus.i_data;
    end else begin : g_chain
      assign wdata = rd[j-1];
    end
    line_store_ram #(
      .N  (N),
      .W  (W),
      .AW (AW)
    ) u_store (
      .clk_i   (i_clk),
      .we_i    (bus.i_valid),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rd[j])
    );
  end

  always_comb begin
    taps_d = '0;
    taps_d[N-1:0] = bus.i_data;
    for (int j = 0; j < K - 1; j++) taps_d[(j+1)*N +: N] = rd[j];
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.i_valid) begin
      if (bus.i_sof) begin
        col_d = AW'(1);
        row_d = '0;
      end else if (col_q == ColLast) begin
        col_d = '0;
        if (row_q != RowSat) row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + AW'(1);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StFill;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.i_valid) begin
      if (bus.i_sof) begin
        state_d = StFill;
      end else if (state_q == StFill && col_q == ColLast && row_q == RowFull) begin
        state_d = StStream;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    filling = (state_q == StFill);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      taps_q  <= '0;
      ocol_q  <= '0;
      eol_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= bus.i_valid && !bus.i_sof && (state_q == StStream);
      if (bus.i_valid) begin
        taps_q <= taps_d;
        ocol_q <= addr;
        eol_q  <= (addr == ColLast);
      end
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_taps    = taps_q;
  assign bus.o_col     = ocol_q;
  assign bus.o_eol     = eol_q;
  assign bus.o_filling = filling;

endmodule
